// File: rtl/player_input_ctrl.sv
// Player input controller: synchronise and debounce raw buttons, then run the select/ready/play flow.
// Latency: raw edge held stable -> press event after 2 + DEBOUNCE_CYCLES cycles; outputs update on the next edge.
// Backpressure: none; every press event is consumed or discarded in the cycle it occurs.
module player_input_ctrl #(
    parameter int N_PLAYERS       = 2,
    parameter int N_CHOICES       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mode,
    input  logic [N_PLAYERS-1:0]                     sel,
    input  logic [N_PLAYERS-1:0]                     conf,
    input  logic                                     start,
    output logic [N_PLAYERS*$clog2(N_CHOICES)-1:0]   choice,
    output logic [N_PLAYERS-1:0]                     locked,
    output logic [1:0]                               state,
    output logic                                     round_start
);
    localparam int SEL_W = $clog2(N_CHOICES);
    localparam int NB    = 2 * N_PLAYERS + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CPU   = N_PLAYERS - 1;

    typedef enum logic [1:0] {
        ST_SELECT = 2'b00,
        ST_READY  = 2'b01,
        ST_PLAY   = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    logic [NB-1:0]        raw, sync1, sync2, deb, deb_d, ev;
    logic [CNT_W-1:0]     cnt [NB];
    logic [15:0]          lfsr;
    logic [SEL_W-1:0]     cpu_pick;
    state_t               cur_state, nxt_state;
    logic [SEL_W-1:0]     choice_q [N_PLAYERS];
    logic [SEL_W-1:0]     choice_n [N_PLAYERS];
    logic [N_PLAYERS-1:0] locked_q, locked_n;
    logic                 round_q, round_n;
    logic [N_PLAYERS-1:0] sel_ev, conf_ev;
    logic                 start_ev;

    // All buttons share one synchroniser/debouncer lane layout: sel, then conf, then start.
    assign raw = {start, conf, sel};

    // Two-flop synchroniser for every raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Press events are rising edges of the debounced level, suppressed while reset is high.
    assign ev       = deb & ~deb_d & {NB{~rst}};
    assign sel_ev   = ev[N_PLAYERS-1:0];
    assign conf_ev  = ev[2*N_PLAYERS-1:N_PLAYERS];
    assign start_ev = ev[NB-1];

    // Free-running Fibonacci LFSR (taps 16,14,13,11) used to pick the CPU choice.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign cpu_pick = SEL_W'(lfsr % 16'(N_CHOICES));

    // Next-state, choice and lock logic; mode only matters while selecting.
    always_comb begin
        nxt_state = cur_state;
        locked_n  = locked_q;
        choice_n  = choice_q;
        round_n   = 1'b0;
        case (cur_state)
            ST_SELECT: begin
                if (&locked_q) begin
                    nxt_state = ST_READY;
                end else begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (!locked_q[i] && !(mode && i == CPU)) begin
                            if (conf_ev[i]) begin
                                locked_n[i] = 1'b1;
                            end else if (sel_ev[i]) begin
                                choice_n[i] = (choice_q[i] == SEL_W'(N_CHOICES - 1)) ? '0
                                                                                     : choice_q[i] + 1'b1;
                            end
                        end
                    end
                    // CPU commits on the same edge player 0 confirms.
                    if (mode && conf_ev[0] && !locked_q[0]) begin
                        locked_n[CPU] = 1'b1;
                        choice_n[CPU] = cpu_pick;
                    end
                end
            end
            ST_READY: begin
                if (start_ev) begin
                    nxt_state = ST_PLAY;
                    round_n   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (start_ev) begin
                    nxt_state = ST_SELECT;
                    locked_n  = '0;
                end
            end
            default: begin
                nxt_state = ST_SELECT;
                locked_n  = '0;
            end
        endcase
    end

    // State, choice, lock and round_start registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_SELECT;
            locked_q  <= '0;
            round_q   <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) choice_q[i] <= '0;
        end else begin
            cur_state <= nxt_state;
            locked_q  <= locked_n;
            round_q   <= round_n;
            choice_q  <= choice_n;
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign choice[g*SEL_W +: SEL_W] = choice_q[g];
    end

    assign locked      = locked_q;
    assign state       = cur_state;
    assign round_start = round_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Self-checking bench for player_input_ctrl: directed scenarios plus randomized button activity.
// A behavioural model (raw-sample window debounce, rule-based game flow) is compared every cycle.
// A second small instance (4 players, 3 choices) checks the non-power-of-two wrap.
module tb_player_input_ctrl;
    localparam int N   = 2;
    localparam int C   = 4;
    localparam int D   = 4;
    localparam int SW  = 2;
    localparam int NB  = 2 * N + 1;
    localparam int N3  = 4;
    localparam int NB3 = 2 * N3 + 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic mode = 1'b0;
    logic [NB-1:0]  raw  = '0;
    logic [NB3-1:0] raw3 = '0;

    logic [N*SW-1:0] choice;
    logic [N-1:0]    locked;
    logic [1:0]      state;
    logic            round_start;
    logic [N3*2-1:0] choice3;
    logic [N3-1:0]   locked3;
    logic [1:0]      state3;
    logic            rs3;

    always #5 clk = ~clk;

    player_input_ctrl #(.N_PLAYERS(N), .N_CHOICES(C), .DEBOUNCE_CYCLES(D)) u_dut (
        .clk(clk), .rst(rst), .mode(mode),
        .sel(raw[N-1:0]), .conf(raw[2*N-1:N]), .start(raw[NB-1]),
        .choice(choice), .locked(locked), .state(state), .round_start(round_start)
    );

    player_input_ctrl #(.N_PLAYERS(N3), .N_CHOICES(3), .DEBOUNCE_CYCLES(D)) u_dut3 (
        .clk(clk), .rst(rst), .mode(1'b0),
        .sel(raw3[N3-1:0]), .conf(raw3[2*N3-1:N3]), .start(raw3[NB3-1]),
        .choice(choice3), .locked(locked3), .state(state3), .round_start(rs3)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 25)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_valid = 1'b0;
    int        m_state;
    int        m_choice [N];
    bit        m_locked [N];
    bit        m_rs;
    bit [15:0] m_lfsr;
    bit        m_deb  [NB];
    bit        m_rose [NB];
    bit        m_evs  [NB];
    bit        hist   [NB][D+2];
    bit        m_all, m_p0, m_agree;

    function automatic bit [15:0] lfsr_next(input bit [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Model update at each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_state = 0;
            m_rs    = 1'b0;
            m_lfsr  = 16'hACE1;
            for (int p = 0; p < N; p++) begin
                m_choice[p] = 0;
                m_locked[p] = 1'b0;
            end
            for (int i = 0; i < NB; i++) begin
                m_deb[i]  = 1'b0;
                m_rose[i] = 1'b0;
                for (int k = 0; k < D + 2; k++) hist[i][k] = 1'b0;
            end
        end else if (m_valid) begin
            for (int i = 0; i < NB; i++) m_evs[i] = m_rose[i];
            m_rs = 1'b0;
            case (m_state)
                0: begin
                    m_all = 1'b1;
                    for (int p = 0; p < N; p++) if (!m_locked[p]) m_all = 1'b0;
                    if (m_all) begin
                        m_state = 1;
                    end else begin
                        m_p0 = m_locked[0];
                        for (int p = 0; p < N; p++) begin
                            if (!m_locked[p] && !(mode && p == N - 1)) begin
                                if (m_evs[N + p])  m_locked[p] = 1'b1;
                                else if (m_evs[p]) m_choice[p] = (m_choice[p] + 1) % C;
                            end
                        end
                        if (mode && m_evs[N] && !m_p0) begin
                            m_locked[N-1] = 1'b1;
                            m_choice[N-1] = int'(m_lfsr) % C;
                        end
                    end
                end
                1: if (m_evs[NB-1]) begin m_state = 2; m_rs = 1'b1; end
                default: if (m_evs[NB-1]) begin
                    m_state = 0;
                    for (int p = 0; p < N; p++) m_locked[p] = 1'b0;
                end
            endcase
            // Debounce: level flips when the last D synchronised samples all disagree with it.
            for (int i = 0; i < NB; i++) begin
                for (int k = D + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = raw[i];
                m_agree = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (hist[i][k] == m_deb[i]) m_agree = 1'b0;
                m_rose[i] = 1'b0;
                if (m_agree) begin
                    m_rose[i] = !m_deb[i];
                    m_deb[i]  = !m_deb[i];
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [31:0] exp_ch, exp_lk;
            exp_ch = '0;
            exp_lk = '0;
            for (int p = 0; p < N; p++) begin
                exp_ch = exp_ch | (32'(m_choice[p]) << (p * SW));
                exp_lk[p] = m_locked[p];
            end
            check("model_state",  32'(state),       32'(m_state));
            check("model_choice", 32'(choice),      exp_ch);
            check("model_locked", 32'(locked),      exp_lk);
            check("model_rstart", 32'(round_start), 32'(m_rs));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic press(input int which, input logic [15:0] mask, input int hold);
        if (which == 0) raw  = raw  | mask[NB-1:0];
        else            raw3 = raw3 | mask[NB3-1:0];
        repeat (hold) @(posedge clk);
        #1;
        if (which == 0) raw  = raw  & ~mask[NB-1:0];
        else            raw3 = raw3 & ~mask[NB3-1:0];
        repeat (D + 6) @(posedge clk);
        #1;
    endtask

    task automatic press_start(output int n);
        n = 0;
        raw[NB-1] = 1'b1;
        for (int k = 0; k < 8 + D + 6; k++) begin
            if (k == 8) raw[NB-1] = 1'b0;
            @(posedge clk);
            #1;
            if (round_start === 1'b1) n++;
        end
    endtask

    int exp_wrap  [4] = '{2, 3, 0, 1};
    int exp_wrap3 [4] = '{1, 2, 0, 1};
    int hc [NB];
    int n_rs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state",  32'(state),       0);
        check("rst_choice", 32'(choice),      0);
        check("rst_locked", 32'(locked),      0);
        check("rst_rstart", 32'(round_start), 0);

        // sel[0] held 20 cycles: choice0 changes on the 7th edge after the raw edge, once.
        raw[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("lat_edge6_choice0", 32'(choice[1:0]), 0);
        @(posedge clk);
        #1;
        check("lat_edge7_choice0", 32'(choice[1:0]), 1);
        repeat (13) @(posedge clk);
        #1;
        raw[0] = 1'b0;
        repeat (D + 6) @(posedge clk);
        #1;
        check("hold_single_event", 32'(choice[1:0]), 1);

        // Single-cycle glitches must not register.
        for (int g = 0; g < 3; g++) begin
            raw[0] = 1'b1;
            @(posedge clk);
            #1;
            raw[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        repeat (8) @(posedge clk);
        #1;
        check("glitch_ignored", 32'(choice[1:0]), 1);

        // Four more presses walk 2,3,0,1.
        for (int k = 0; k < 4; k++) begin
            press(0, 16'h0001, 8);
            check("wrap_choice0", 32'(choice[1:0]), 32'(exp_wrap[k]));
        end

        // Player 1 to choice 2, then simultaneous sel+conf locks without incrementing.
        press(0, 16'h0002, 8);
        press(0, 16'h0002, 8);
        check("p1_choice2", 32'(choice[3:2]), 2);
        press(0, 16'h000A, 8);
        check("selconf_locked", 32'(locked), 2);
        check("selconf_choice", 32'(choice[3:2]), 2);
        press(0, 16'h0002, 8);
        check("locked_sel_ignored", 32'(choice[3:2]), 2);

        // Both locked -> READY; start -> PLAY with one round_start; start -> SELECT.
        press(0, 16'h0004, 8);
        check("all_locked", 32'(locked), 3);
        check("ready_state", 32'(state), 1);
        press_start(n_rs);
        check("rstart_pulses", 32'(n_rs), 1);
        check("play_state", 32'(state), 2);
        press_start(n_rs);
        check("no_rstart_leave", 32'(n_rs), 0);
        check("back_select", 32'(state), 0);
        check("back_unlocked", 32'(locked), 0);
        check("choices_kept", 32'(choice), 32'h9);

        // CPU mode: player 1 buttons ignored; player 0 confirm locks both.
        mode = 1'b1;
        press(0, 16'h0002, 8);
        check("cpu_sel_ignored", 32'(choice[3:2]), 2);
        press(0, 16'h0008, 8);
        check("cpu_conf_ignored", 32'(locked), 0);
        press(0, 16'h0004, 8);
        check("cpu_locked_both", 32'(locked), 3);
        check("cpu_ready", 32'(state), 1);
        press_start(n_rs);
        check("cpu_play", 32'(state), 2);

        // Reset in PLAY while sel[0] is mid-debounce; button stays held through release.
        raw[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_state",  32'(state),       0);
        check("midrst_choice", 32'(choice),      0);
        check("midrst_locked", 32'(locked),      0);
        check("midrst_rstart", 32'(round_start), 0);
        repeat (12) @(posedge clk);
        #1;
        check("held_through_rst", 32'(choice[1:0]), 1);
        raw[0] = 1'b0;
        repeat (D + 6) @(posedge clk);
        #1;

        // Four players, three choices: wrap 2 -> 0.
        for (int k = 0; k < 4; k++) begin
            press(1, 16'h0001, 8);
            check("wrap3_choice0", 32'(choice3[1:0]), 32'(exp_wrap3[k]));
        end

        // Randomized button activity with occasional glitches, mode flips and resets.
        mode = 1'b0;
        for (int i = 0; i < NB; i++) hc[i] = $urandom_range(0, 10);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NB; i++) begin
                if (hc[i] == 0) begin
                    raw[i] = ~raw[i];
                    hc[i]  = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(5, 14));
                end else begin
                    hc[i]--;
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 249) == 0) mode = ~mode;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        raw = '0;
        repeat (4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of player button pairs (2..8).
REQ-002 SHALL have parameter N_CHOICES, default 4, selectable options per player (2..16); SEL_W = clog2(N_CHOICES).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles before a button level is accepted.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode  input  1  0 = all human players; 1 = player N_PLAYERS-1 is CPU.
REQ-007 SHALL have port sel  input  N_PLAYERS  raw asynchronous select buttons, bit i = player i.
REQ-008 SHALL have port conf  input  N_PLAYERS  raw asynchronous confirm buttons.
REQ-009 SHALL have port start  input  1  raw asynchronous start button.
REQ-010 SHALL have port choice  output  N_PLAYERS*SEL_W  current choice per player, player i at bits [i*SEL_W +: SEL_W].
REQ-011 SHALL have port locked  output  N_PLAYERS  player i has confirmed.
REQ-012 SHALL have port state  output  2  00 SELECT, 01 READY, 10 PLAY.
REQ-013 SHALL have port round_start  output  1  one-cycle pulse on entry to PLAY.

Function
REQ-014 Each raw input SHALL pass a 2-flop synchroniser, then a per-input debouncer: debounced level takes the synchronised value after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 A press event SHALL be a one-cycle pulse on the 0->1 transition of a debounced level; release produces no event; holding produces exactly one event.
REQ-016 Latency raw edge (held stable) -> press event SHALL be exactly 2 + DEBOUNCE_CYCLES cycles; choice/locked/state update on the following edge.
REQ-017 SELECT: sel event for unlocked player i SHALL increment choice[i], wrapping N_CHOICES-1 -> 0.
REQ-018 SELECT: conf event for unlocked player i SHALL set locked[i]; choice[i] frozen.
REQ-019 Same-cycle sel and conf events for one player SHALL lock only, no increment.
REQ-020 Events from different players in the same cycle SHALL all be applied independently.
REQ-021 Events from locked players, and sel/conf events in READY or PLAY, SHALL be ignored.
REQ-022 mode=1: CPU player's sel/conf SHALL be ignored; when player 0 locks, CPU choice SHALL be loaded from a free-running 16-bit LFSR (taps 16,14,13,11, seed 0xACE1, advancing every cycle) as lfsr mod N_CHOICES, and locked[N_PLAYERS-1] set on the same edge.
REQ-023 mode SHALL be sampled only in SELECT; changes in READY/PLAY take effect at next SELECT entry.
REQ-024 SELECT -> READY SHALL occur on the edge after all locked bits are 1.
REQ-025 READY: start event SHALL move to PLAY and assert round_start for exactly that one cycle.
REQ-026 PLAY: start event SHALL return to SELECT, clear all locked bits, keep choice values.
REQ-027 start events in SELECT SHALL be ignored.
REQ-028 State encoding 11 SHALL be unreachable; if entered, next state is SELECT with locks cleared.

Reset
REQ-029 rst=1 on a rising edge SHALL set state=SELECT, choice all 0, locked all 0, round_start 0, all debounced levels 0, debounce counters 0, synchronisers 0, LFSR 0xACE1.
REQ-030 Reset mid-operation (any state, any debounce count) SHALL discard pending presses; a button held through reset release SHALL produce one event after 2 + DEBOUNCE_CYCLES cycles.
REQ-031 No press event SHALL be generated during the cycle rst is asserted.

Verification (DEBOUNCE_CYCLES=4, N_PLAYERS=2, N_CHOICES=4 unless noted)
REQ-032 sel[0] held high 20 cycles -> single event, choice0 0->1 on cycle 7 after raw edge; 1-cycle glitches on sel[0] -> no change.
REQ-033 Four sel[0] presses then a fifth -> choice0 1,2,3,0,1 (wrap).
REQ-034 sel[1] and conf[1] pressed same cycle with choice1=2 -> locked1=1, choice1 stays 2; later sel[1] press -> no change.
REQ-035 mode=0: conf[0], conf[1] -> state READY; start -> state PLAY, round_start high 1 cycle; start again -> SELECT, locked=00, choices unchanged.
REQ-036 mode=1: conf[0] only -> locked=11 same edge, choice1 equals LFSR mod 4 at that edge; sel[1]/conf[1] presses ignored.
REQ-037 rst pulse while in PLAY with sel[0] mid-debounce -> all outputs reset values next edge, no spurious event; N_PLAYERS=4, N_CHOICES=3 rerun of REQ-033 wraps 2 -> 0.
